// File: rtl/genius_pkg.sv
// genius_pkg
//   Shared definitions for the N-button memory-game sequencer.
//   - estado_t : FSM state encoding; the codes double as the db_estado debug output
//                (IDLE=0 .. FIM_ERRO=A).
//   - eh_onehot: true when exactly one bit of the (zero-extended) input is set.
package genius_pkg;

  typedef enum logic [3:0] {
    StIdle      = 4'h0,
    StPrep      = 4'h1,
    StMostraOn  = 4'h2,
    StMostraOff = 4'h3,
    StEspera    = 4'h4,
    StCompara   = 4'h5,
    StProx      = 4'h6,
    StNova      = 4'h7,
    StGrava     = 4'h8,
    StFimOk     = 4'h9,
    StFimErro   = 4'hA
  } estado_t;

  function automatic logic eh_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/temporizador_n.sv
// temporizador_n
//   Free-running phase timer: counts 0..M-1 while enabled and flags the last count.
// Ports
//   clock     in  system clock, rising edge
//   reset     in  asynchronous active-low reset
//   i_carrega in  synchronous clear to 0 (wins over i_conta)
//   i_conta   in  count enable
//   o_fim     out high while the count equals M-1
module temporizador_n #(
  parameter int unsigned M = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_carrega,
  input  logic i_conta,
  output logic o_fim
);

  localparam int unsigned W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] r_cont;

  assign o_fim = (r_cont == W'(M - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cont <= '0;
    end else if (i_carrega) begin
      r_cont <= '0;
    end else if (i_conta) begin
      r_cont <= o_fim ? '0 : r_cont + W'(1);
    end
  end

endmodule

// File: rtl/genius_sequenciador_n.sv
// genius_sequenciador_n
//   Sequencer for an N-button memory game: records the player-built sequence, replays it on
//   the LEDs with timed on/off phases, checks each echoed press and appends one press per round.
//   Optional feature macro: TIMEOUT_EN (per-press timeout; without it the game waits forever).
// Ports
//   clock, reset  system clock / asynchronous active-low reset
//   iniciar       start pulse (IDLE only); limite_jogo latched with it (index of final round)
//   botoes        synchronised button levels
//   leds          one-hot LED drive (replay in MOSTRA_ON, button echo in ESPERA)
//   pronto        1-cycle end-of-game pulse
//   ganhou, errou, timeout_err  result flags, held until next iniciar
//   db_estado, db_rodada, db_endereco  debug: state code, round, address
module genius_sequenciador_n
  import genius_pkg::*;
#(
  parameter int unsigned N_BOTOES  = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned T_LED_ON  = 2000,
  parameter int unsigned T_LED_OFF = 1000,
  parameter int unsigned T_TIMEOUT = 5000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [AW-1:0]       limite_jogo,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                ganhou,
  output logic                errou,
  output logic                timeout_err,
  output logic [3:0]          db_estado,
  output logic [AW-1:0]       db_rodada,
  output logic [AW-1:0]       db_endereco
);

  estado_t             r_estado, w_estado_prox;
  logic [AW-1:0]       r_rodada, w_rodada_prox;
  logic [AW-1:0]       r_endereco, w_endereco_prox;
  logic [AW-1:0]       r_limite;
  logic [N_BOTOES-1:0] r_jogada;
  logic                r_invalida;
  logic                r_botao_ant;
  logic                r_ganhou, r_errou, r_timeout;
  logic [N_BOTOES-1:0] r_mem [DEPTH];

  logic w_press, w_valida, w_ultimo;
  logic w_on_fim, w_off_fim, w_to_fim;
  logic w_limpa, w_captura, w_set_ganhou, w_set_errou, w_set_timeout;

  // Press = rising edge of "any button down"
  assign w_press  = (|botoes) & ~r_botao_ant;
  assign w_valida = eh_onehot(32'(botoes));
  assign w_ultimo = (r_endereco == (r_rodada - AW'(1)));

  temporizador_n #(.M(T_LED_ON)) u_tmr_on (
    .clock     (clock),
    .reset     (reset),
    .i_carrega (r_estado != StMostraOn),
    .i_conta   (r_estado == StMostraOn),
    .o_fim     (w_on_fim)
  );

  temporizador_n #(.M(T_LED_OFF)) u_tmr_off (
    .clock     (clock),
    .reset     (reset),
    .i_carrega (r_estado != StMostraOff),
    .i_conta   (r_estado == StMostraOff),
    .o_fim     (w_off_fim)
  );

`ifdef TIMEOUT_EN
  // Restarts on every entry to a waiting state (COMPARA/PROX/PREP sit in between)
  temporizador_n #(.M(T_TIMEOUT)) u_tmr_to (
    .clock     (clock),
    .reset     (reset),
    .i_carrega (!((r_estado == StEspera) || (r_estado == StNova))),
    .i_conta   ((r_estado == StEspera) || (r_estado == StNova)),
    .o_fim     (w_to_fim)
  );
`else
  // No timer: r_timeout can never be set, so timeout_err stays 0
  assign w_to_fim = 1'b0;
`endif

  always_comb begin
    w_estado_prox   = r_estado;
    w_rodada_prox   = r_rodada;
    w_endereco_prox = r_endereco;
    w_limpa         = 1'b0;
    w_captura       = 1'b0;
    w_set_ganhou    = 1'b0;
    w_set_errou     = 1'b0;
    w_set_timeout   = 1'b0;
    unique case (r_estado)
      StIdle: begin
        if (iniciar) begin
          w_limpa         = 1'b1;
          w_rodada_prox   = '0;
          w_endereco_prox = '0;
          w_estado_prox   = StPrep;
        end
      end
      StPrep: begin
        w_endereco_prox = '0;
        w_estado_prox   = (r_rodada == '0) ? StNova : StMostraOn;
      end
      StMostraOn: begin
        if (w_on_fim) w_estado_prox = StMostraOff;
      end
      StMostraOff: begin
        if (w_off_fim) begin
          if (w_ultimo) begin
            w_endereco_prox = '0;
            w_estado_prox   = StEspera;
          end else begin
            w_endereco_prox = r_endereco + AW'(1);
            w_estado_prox   = StMostraOn;
          end
        end
      end
      StEspera: begin
        // A press on the timeout cycle still counts
        if (w_press) begin
          w_captura     = 1'b1;
          w_estado_prox = StCompara;
        end else if (w_to_fim) begin
          w_set_timeout = 1'b1;
          w_estado_prox = StFimErro;
        end
      end
      StCompara: begin
        if (!r_invalida && (r_jogada == r_mem[r_endereco])) begin
          w_estado_prox = StProx;
        end else begin
          w_set_errou   = 1'b1;
          w_estado_prox = StFimErro;
        end
      end
      StProx: begin
        if (w_ultimo) begin
          w_estado_prox = StNova;
        end else begin
          w_endereco_prox = r_endereco + AW'(1);
          w_estado_prox   = StEspera;
        end
      end
      StNova: begin
        if (w_press) begin
          if (w_valida) begin
            w_captura     = 1'b1;
            w_estado_prox = StGrava;
          end else begin
            w_set_errou   = 1'b1;
            w_estado_prox = StFimErro;
          end
        end else if (w_to_fim) begin
          w_set_timeout = 1'b1;
          w_estado_prox = StFimErro;
        end
      end
      StGrava: begin
        if (r_rodada == r_limite) begin
          w_set_ganhou  = 1'b1;
          w_estado_prox = StFimOk;
        end else begin
          w_rodada_prox = r_rodada + AW'(1);
          w_estado_prox = StPrep;
        end
      end
      StFimOk, StFimErro: w_estado_prox = StIdle;
      default:            w_estado_prox = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado    <= StIdle;
      r_rodada    <= '0;
      r_endereco  <= '0;
      r_limite    <= '0;
      r_jogada    <= '0;
      r_invalida  <= 1'b0;
      r_botao_ant <= 1'b0;
      r_ganhou    <= 1'b0;
      r_errou     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_estado    <= w_estado_prox;
      r_rodada    <= w_rodada_prox;
      r_endereco  <= w_endereco_prox;
      r_botao_ant <= |botoes;
      if (w_limpa) begin
        r_limite  <= limite_jogo;
        r_ganhou  <= 1'b0;
        r_errou   <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_captura) begin
        r_jogada   <= botoes;
        r_invalida <= !w_valida;
      end
      if (w_set_ganhou)  r_ganhou  <= 1'b1;
      if (w_set_errou)   r_errou   <= 1'b1;
      if (w_set_timeout) r_timeout <= 1'b1;
    end
  end

  // Sequence storage: not reset, written one cycle after the press is captured
  always_ff @(posedge clock) begin
    if (r_estado == StGrava) r_mem[r_rodada] <= r_jogada;
  end

  always_comb begin
    leds = '0;
    if (r_estado == StMostraOn)    leds = r_mem[r_endereco];
    else if (r_estado == StEspera) leds = botoes;
  end

  assign pronto      = (r_estado == StFimOk) || (r_estado == StFimErro);
  assign ganhou      = r_ganhou;
  assign errou       = r_errou;
  assign timeout_err = r_timeout;
  assign db_estado   = r_estado;
  assign db_rodada   = r_rodada;
  assign db_endereco = r_endereco;

endmodule

// File: tb/tb_genius_sequenciador_n.sv
// tb_genius_sequenciador_n
//   Directed bench for genius_sequenciador_n with default parameters (N=4, DEPTH=16).
module tb_genius_sequenciador_n;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] limite_jogo;
  logic [3:0] botoes;
  logic [3:0] leds;
  logic       pronto, ganhou, errou, timeout_err;
  logic [3:0] db_estado, db_rodada, db_endereco;

  int n_checks = 0;
  int n_fail   = 0;

  genius_sequenciador_n dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .limite_jogo (limite_jogo),
    .botoes      (botoes),
    .leds        (leds),
    .pronto      (pronto),
    .ganhou      (ganhou),
    .errou       (errou),
    .timeout_err (timeout_err),
    .db_estado   (db_estado),
    .db_rodada   (db_rodada),
    .db_endereco (db_endereco)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_estado(input string tag, input logic [3:0] alvo, input int budget);
    int n = 0;
    while (db_estado != alvo && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, db_estado, alvo);
  endtask

  task automatic press_once(input logic [3:0] v);
    botoes = v;
    tick();
    botoes = '0;
  endtask

  task automatic start(input logic [3:0] lim);
    limite_jogo = lim;
    iniciar     = 1'b1;
    tick();
    iniciar     = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    logic [3:0] pat [6];
    pat[0] = 4'b0001; pat[1] = 4'b0000; pat[2] = 4'b0110;
    pat[3] = 4'b0000; pat[4] = 4'b1000; pat[5] = 4'b0000;

    reset = 1'b0; iniciar = 1'b0; botoes = '0; limite_jogo = '0;
    repeat (3) tick();
    check_val("rst_estado", db_estado, 4'h0);
    check_val("rst_leds", leds, 4'h0);
    check_val("rst_flags", {pronto, ganhou, errou, timeout_err}, 4'h0);
    check_val("rst_rodada", db_rodada, 4'h0);
    check_val("rst_endereco", db_endereco, 4'h0);
    reset = 1'b1;
    tick();

    // Winning game with limite 2, and exact replay timing in round 1
    start(4'd2);
    check_val("t1_prep", db_estado, 4'h1);
    tick();
    check_val("t1_nova_r0", db_estado, 4'h7);
    press_once(4'b0001);
    check_val("t1_grava", db_estado, 4'h8);
    tick();
    check_val("t1_prep_r1", db_estado, 4'h1);
    check_val("t1_rodada1", db_rodada, 4'd1);
    tick();
    check_val("t2_mostra_on", db_estado, 4'h2);
    n = 0; bad = 0;
    while (db_estado == 4'h2 && n < 5000) begin
      if (leds !== 4'b0001) bad++;
      n++;
      tick();
    end
    check_val("t2_on_len", n, 2000);
    check_val("t2_on_leds", bad, 0);
    n = 0; bad = 0;
    while (db_estado == 4'h3 && n < 5000) begin
      if (leds !== 4'b0000) bad++;
      n++;
      tick();
    end
    check_val("t2_off_len", n, 1000);
    check_val("t2_off_leds", bad, 0);
    check_val("t2_espera", db_estado, 4'h4);
    botoes = 4'b0001;
    #1;
    check_val("t1_echo_leds", leds, 4'b0001);
    tick();
    botoes = '0;
    check_val("t1_compara", db_estado, 4'h5);
    wait_estado("t1_nova_r1", 4'h7, 5);
    press_once(4'b0010);
    tick();
    check_val("t1_rodada2", db_rodada, 4'd2);
    wait_estado("t1_on_r2a", 4'h2, 5);
    check_val("t1_replay0", leds, 4'b0001);
    wait_estado("t1_off_r2a", 4'h3, 2500);
    wait_estado("t1_on_r2b", 4'h2, 1500);
    check_val("t1_replay1", leds, 4'b0010);
    wait_estado("t1_espera_r2", 4'h4, 4000);
    press_once(4'b0001);
    wait_estado("t1_espera_r2b", 4'h4, 5);
    press_once(4'b0010);
    wait_estado("t1_nova_r2", 4'h7, 5);
    press_once(4'b0100);
    check_val("t1_grava_r2", db_estado, 4'h8);
    tick();
    check_val("t1_fim_ok", db_estado, 4'h9);
    check_val("t1_pronto", pronto, 1'b1);
    check_val("t1_ganhou", ganhou, 1'b1);
    check_val("t1_errou", errou, 1'b0);
    tick();
    check_val("t1_idle", db_estado, 4'h0);
    check_val("t1_pronto_off", pronto, 1'b0);
    check_val("t1_ganhou_held", ganhou, 1'b1);
    check_val("t1_mem0", dut.r_mem[0], 4'b0001);
    check_val("t1_mem1", dut.r_mem[1], 4'b0010);
    check_val("t1_mem2", dut.r_mem[2], 4'b0100);

    // Wrong echo in round 2
    start(4'd2);
    check_val("t3_ganhou_clr", ganhou, 1'b0);
    wait_estado("t3_nova_r0", 4'h7, 3);
    press_once(4'b0001);
    wait_estado("t3_espera_r1", 4'h4, 4000);
    press_once(4'b0001);
    wait_estado("t3_nova_r1", 4'h7, 5);
    press_once(4'b0010);
    wait_estado("t3_espera_r2", 4'h4, 7000);
    press_once(4'b0001);
    wait_estado("t3_espera_r2b", 4'h4, 5);
    press_once(4'b1000);
    check_val("t3_compara", db_estado, 4'h5);
    tick();
    check_val("t3_fim_erro", db_estado, 4'hA);
    check_val("t3_pronto", pronto, 1'b1);
    tick();
    check_val("t3_idle", db_estado, 4'h0);
    check_val("t3_flags", {ganhou, errou, timeout_err}, 3'b010);

    // Multi-bit press in NOVA, then button noise in IDLE
    start(4'd0);
    wait_estado("t4_nova", 4'h7, 3);
    press_once(4'b0011);
    check_val("t4_fim_erro", db_estado, 4'hA);
    check_val("t4_errou", errou, 1'b1);
    tick();
    check_val("t4_idle", db_estado, 4'h0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      botoes = pat[i];
      tick();
      if (db_estado !== 4'h0 || leds !== 4'h0) bad++;
    end
    botoes = '0;
    check_val("t4_idle_noise", bad, 0);

    // Waiting in ESPERA with no press
    start(4'd2);
    wait_estado("t5_nova", 4'h7, 3);
    press_once(4'b0001);
    wait_estado("t5_espera", 4'h4, 4000);
    n = 0;
`ifdef TIMEOUT_EN
    while (db_estado == 4'h4 && n < 30000) begin
      n++;
      tick();
    end
    check_val("t5_to_len", n, 5000);
    check_val("t5_to_estado", db_estado, 4'hA);
    check_val("t5_to_flags", {errou, timeout_err}, 2'b01);
    tick();
    check_val("t5_to_idle", db_estado, 4'h0);
`else
    while (db_estado == 4'h4 && n < 20000) begin
      n++;
      tick();
    end
    check_val("t5_no_to_len", n, 20000);
    check_val("t5_still_espera", db_estado, 4'h4);
    check_val("t5_no_to_flag", timeout_err, 1'b0);
`endif

    // Asynchronous reset during replay
    reset = 1'b1;
    tick();
    if (db_estado != 4'h0) begin
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
    end
    start(4'd1);
    wait_estado("t6_nova", 4'h7, 3);
    press_once(4'b0001);
    wait_estado("t6_mostra_on", 4'h2, 5);
    repeat (10) tick();
    #2;
    reset = 1'b0;
    #1;
    check_val("t6_rst_leds", leds, 4'h0);
    check_val("t6_rst_estado", db_estado, 4'h0);
    check_val("t6_rst_rodada", db_rodada, 4'h0);
    tick();
    reset = 1'b1;
    tick();
    start(4'd3);
    check_val("t6_restart_prep", db_estado, 4'h1);
    check_val("t6_restart_rodada", db_rodada, 4'h0);
    tick();
    check_val("t6_restart_nova", db_estado, 4'h7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
